adc_udp_packetizer: RTL and testbench
=====================================

ADC_UDP_PACKETIZER -- requirements
Module: adc_udp_packetizer

Interface
REQ-001 SHALL have parameter PKT_WORDS, default 512, sample words per full packet (legal range 1..2047).
REQ-002 SHALL have parameter HDR_MAGIC, default 16'hA55A, first header word of every packet.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port eth_busy  input  1  capture/send job active, high while the upstream sender state machine is out of idle.
REQ-006 SHALL have port eth_done_pulse  input  1  one-cycle pulse when the upstream sender finishes writing a job.
REQ-007 SHALL have port fifo_dout  input  16  show-ahead tx FIFO head word, valid while fifo_empty=0.
REQ-008 SHALL have port fifo_empty  input  1  tx FIFO empty.
REQ-009 SHALL have port fifo_rdusedw  input  12  tx FIFO fill level in words.
REQ-010 SHALL have port fifo_rden  output  1  tx FIFO read acknowledge (pops head).
REQ-011 SHALL have port tx_start  output  1  one-cycle pulse requesting a UDP packet.
REQ-012 SHALL have port tx_len  output  16  UDP payload length in bytes, stable from tx_start until tx_done.
REQ-013 SHALL have port tx_data_req  input  1  UDP core requests one payload word per high cycle.
REQ-014 SHALL have port tx_data  output  16  payload word, valid the cycle after the matching tx_data_req.
REQ-015 SHALL have port tx_done  input  1  one-cycle pulse when the UDP core has sent the packet.
REQ-016 SHALL have port pkt_cnt  output  16  packets completed since the current job started.
REQ-017 SHALL have port underflow  output  1  sticky error flag, set when a payload word is requested while the FIFO is empty.

Function
REQ-018 SHALL implement states IDLE, START, HDR0, HDR1, PAYLOAD, WAIT_DONE.
REQ-019 IDLE SHALL move to START when fifo_rdusedw>=PKT_WORDS; pkt_words SHALL latch PKT_WORDS.
REQ-020 IDLE SHALL move to START when flush_pending=1 and fifo_empty=0; pkt_words SHALL latch min(fifo_rdusedw, PKT_WORDS).
REQ-021 flush_pending SHALL be set by eth_done_pulse in any state.
REQ-022 flush_pending SHALL clear in IDLE when fifo_empty=1 and eth_done_pulse=0; if eth_done_pulse and the clear coincide, set SHALL win.
REQ-023 START SHALL assert tx_start for exactly one cycle, register tx_len=(pkt_words+2)*2 computed in 16 bits, then go to HDR0.
REQ-024 HDR0 SHALL wait for tx_data_req, then register tx_data<=HDR_MAGIC and go to HDR1.
REQ-025 HDR1 SHALL wait for tx_data_req, then register tx_data<=seq and go to PAYLOAD.
REQ-026 In PAYLOAD, fifo_rden SHALL equal tx_data_req (combinational); each request SHALL register tx_data<=fifo_dout and decrement the word counter.
REQ-027 On the request for the last payload word, the block SHALL go to WAIT_DONE.
REQ-028 In PAYLOAD, a tx_data_req while fifo_empty=1 SHALL set underflow, register tx_data<=0, still count the word, and assert fifo_rden=0.
REQ-029 tx_data_req SHALL be ignored outside HDR0/HDR1/PAYLOAD; fifo_rden SHALL be 0 outside PAYLOAD.
REQ-030 WAIT_DONE SHALL hold until tx_done, then increment seq (16-bit, wraps FFFF->0000) and pkt_cnt (16-bit, wraps), and go to IDLE.
REQ-031 A rising edge of eth_busy (registered previous value) SHALL clear seq, pkt_cnt and underflow only when state=IDLE.
REQ-032 If the eth_busy rising edge occurs outside IDLE, the clear SHALL be held pending and applied on the next return to IDLE.
REQ-033 tx_data SHALL hold its last value between requests.

Reset
REQ-034 reset_n=0 SHALL asynchronously force the following: state=IDLE, tx_start=0, tx_len=0, tx_data=0, pkt_cnt=0, seq=0, underflow=0, flush_pending=0, and pending clear=0.
REQ-035 fifo_rden SHALL be 0 during reset.
REQ-036 Reset mid-packet SHALL abandon the packet without any further FIFO reads.

Verification
REQ-037 Fill the FIFO to 512 words with ramp 0..511 and request continuously -> one tx_start with tx_len=1028, tx_data stream A55A,0000,0000..01FF, 512 fifo_rden pulses, and pkt_cnt=1 after tx_done.
REQ-038 Write 1100 words then pulse eth_done_pulse -> packets of 512, 512, 76 words with tx_len 1028, 1028, 156, seq 0,1,2, and flush_pending=0 at the end.
REQ-039 Stall tx_data_req randomly, including zero-gap and 5-cycle gaps -> data order and counts are unchanged, and tx_data only updates the cycle after each request.
REQ-040 Empty the FIFO after 300 payload words of a 512-word packet -> underflow=1, the remaining words are 0000, and the packet still completes.
REQ-041 Assert reset_n=0 for 1 cycle during PAYLOAD -> all outputs return to their reset values immediately, and no fifo_rden occurs until the next trigger.
REQ-042 Raise eth_busy while in WAIT_DONE with seq=5 -> after tx_done, seq and pkt_cnt are 0 in IDLE and the next header carries seq 0000.

Source files
------------

// File: rtl/adc_udp_packetizer.sv
// Purpose: frames ADC samples from a show-ahead tx FIFO into UDP payloads: magic, seq, then N samples.
// Latency: tx_start one cycle after the launch decision; tx_data valid the cycle after each tx_data_req.
// Backpressure: UDP core paces payload via tx_data_req; FIFO popped only on granted, non-empty requests.
//
// Ports:
//   clk, reset_n       single clock, asynchronous active-low reset
//   eth_busy           upstream job active; its rising edge starts a new job (clears seq/pkt_cnt/underflow)
//   eth_done_pulse     upstream job finished; remaining FIFO words are flushed as a short packet
//   fifo_dout/empty/rdusedw, fifo_rden   show-ahead FIFO read side
//   tx_start, tx_len, tx_data_req, tx_data, tx_done   UDP core handshake
//   pkt_cnt, underflow status: packets sent in this job, sticky empty-read error
module adc_udp_packetizer #(
  parameter int unsigned PKT_WORDS = 512,
  parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eth_busy,
  input  logic        eth_done_pulse,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic [11:0] fifo_rdusedw,
  output logic        fifo_rden,
  output logic        tx_start,
  output logic [15:0] tx_len,
  input  logic        tx_data_req,
  output logic [15:0] tx_data,
  input  logic        tx_done,
  output logic [15:0] pkt_cnt,
  output logic        underflow
);

  localparam logic [11:0] LP_PKT_WORDS = 12'(PKT_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HDR0, S_HDR1, S_PAYLOAD, S_WAIT_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_busy_d;
  logic        r_flush_pending;
  logic        r_clr_pending;
  logic [15:0] r_seq;
  logic [15:0] r_pkt_cnt;
  logic        r_underflow;
  logic [15:0] r_tx_len;
  logic [15:0] r_tx_data;
  logic [11:0] r_words_left;

  logic        w_busy_rise;
  logic        w_launch_full;
  logic        w_launch_flush;
  logic        w_launch;
  logic [11:0] w_launch_words;
  logic [15:0] w_tx_len;
  logic        w_last_word;

  assign w_busy_rise    = eth_busy && !r_busy_d;
  assign w_launch_full  = (fifo_rdusedw >= LP_PKT_WORDS);
  assign w_launch_flush = r_flush_pending && !fifo_empty;
  assign w_launch       = w_launch_full || w_launch_flush;
  // A flush packet takes whatever is buffered, capped at a full packet.
  assign w_launch_words = (fifo_rdusedw < LP_PKT_WORDS) ? fifo_rdusedw : LP_PKT_WORDS;
  // Payload bytes include the two header words.
  assign w_tx_len       = ({4'b0, w_launch_words} + 16'd2) << 1;
  // "<= 1" also terminates a degenerate zero-length flush instead of wrapping.
  assign w_last_word    = (r_words_left <= 12'd1);

  assign tx_len    = r_tx_len;
  assign tx_data   = r_tx_data;
  assign pkt_cnt   = r_pkt_cnt;
  assign underflow = r_underflow;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_launch)    w_state_nxt = S_START;
      S_START:                      w_state_nxt = S_HDR0;
      S_HDR0:      if (tx_data_req) w_state_nxt = S_HDR1;
      S_HDR1:      if (tx_data_req) w_state_nxt = S_PAYLOAD;
      S_PAYLOAD:   if (tx_data_req && w_last_word) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done)     w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the FIFO is never popped when it has nothing to give.
  always_comb begin
    tx_start  = 1'b0;
    fifo_rden = 1'b0;
    case (r_state)
      S_START:   tx_start  = 1'b1;
      S_PAYLOAD: fifo_rden = tx_data_req && !fifo_empty;
      default: ;
    endcase
  end

  // Datapath and bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_d        <= 1'b0;
      r_flush_pending <= 1'b0;
      r_clr_pending   <= 1'b0;
      r_seq           <= 16'd0;
      r_pkt_cnt       <= 16'd0;
      r_underflow     <= 1'b0;
      r_tx_len        <= 16'd0;
      r_tx_data       <= 16'd0;
      r_words_left    <= 12'd0;
    end else begin
      r_busy_d <= eth_busy;

      // A new done pulse always wins over the idle/empty clear.
      if (eth_done_pulse)                        r_flush_pending <= 1'b1;
      else if (r_state == S_IDLE && fifo_empty)  r_flush_pending <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_words_left <= w_launch_full ? LP_PKT_WORDS : w_launch_words;
            r_tx_len     <= w_launch_full ? ({4'b0, LP_PKT_WORDS} + 16'd2) << 1 : w_tx_len;
          end
        end
        S_HDR0: if (tx_data_req) r_tx_data <= HDR_MAGIC;
        S_HDR1: if (tx_data_req) r_tx_data <= r_seq;
        S_PAYLOAD: begin
          if (tx_data_req) begin
            // Starved reads still consume a slot so the packet length stays as announced.
            r_tx_data    <= fifo_empty ? 16'd0 : fifo_dout;
            r_words_left <= r_words_left - 12'd1;
            if (fifo_empty) r_underflow <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            r_seq     <= r_seq + 16'd1;
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end
        end
        default: ;
      endcase

      // Job restart only takes effect between packets so a packet in flight keeps its numbering.
      if (w_busy_rise && r_state != S_IDLE) r_clr_pending <= 1'b1;
      if (r_state == S_IDLE && (w_busy_rise || r_clr_pending)) begin
        r_seq         <= 16'd0;
        r_pkt_cnt     <= 16'd0;
        r_underflow   <= 1'b0;
        r_clr_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_udp_packetizer.sv
// Purpose: scoreboard bench for adc_udp_packetizer with a behavioural show-ahead FIFO and UDP sink.
// Latency: checks tx_data one cycle after each tx_data_req, pkt_cnt one cycle after tx_done.
// Backpressure: sink stalls tx_data_req continuously or with random 1..5 cycle gaps.
module tb_adc_udp_packetizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eth_busy;
  logic        eth_done_pulse;
  logic [15:0] fifo_dout = 16'h0;
  logic        fifo_empty = 1'b1;
  logic [11:0] fifo_rdusedw = 12'h0;
  logic        fifo_rden;
  logic        tx_start;
  logic [15:0] tx_len;
  logic        tx_data_req;
  logic [15:0] tx_data;
  logic        tx_done;
  logic [15:0] pkt_cnt;
  logic        underflow;

  always #5 clk = ~clk;

  adc_udp_packetizer #(.PKT_WORDS(512), .HDR_MAGIC(16'hA55A)) dut (
    .clk(clk), .reset_n(reset_n), .eth_busy(eth_busy), .eth_done_pulse(eth_done_pulse),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rdusedw(fifo_rdusedw),
    .fifo_rden(fifo_rden), .tx_start(tx_start), .tx_len(tx_len), .tx_data_req(tx_data_req),
    .tx_data(tx_data), .tx_done(tx_done), .pkt_cnt(pkt_cnt), .underflow(underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard queues, filled by the stimulus, drained by the sink.
  logic [15:0] exp_pay[$];
  logic [15:0] exp_len[$];
  logic [15:0] exp_seq[$];
  logic [15:0] exp_cnt[$];
  int          exp_rden[$];

  // Behavioural show-ahead FIFO
  logic        wr_en   = 1'b0;
  logic [15:0] wr_dat  = 16'h0;
  logic        clr_req = 1'b0;
  int          rden_total = 0;
  logic [15:0] fq[$];

  initial begin
    forever begin
      @(posedge clk);
      if (fifo_rden) rden_total++;
      if (clr_req) fq.delete();
      else begin
        if (fifo_rden && fq.size() > 0) void'(fq.pop_front());
        if (wr_en) fq.push_back(wr_dat);
      end
      fifo_empty   <= (fq.size() == 0);
      fifo_rdusedw <= 12'(fq.size());
      fifo_dout    <= (fq.size() > 0) ? fq[0] : 16'h0;
    end
  end

  // UDP sink
  int          st = 0;
  int          w, got = 0, nwords, cur_rden, rden_base, gap_left, dly;
  int          pkts_done = 0;
  int          req_limit = 4096;
  bit          gap_mode = 1'b0, abort = 1'b0, spam_req = 1'b0, words_done = 1'b0;
  bit          req_d, req, first;
  logic [15:0] cur_len, cur_seq, cur_cnt, last_exp, e;

  initial begin
    tx_data_req = 1'b0;
    tx_done     = 1'b0;
    req_d       = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (abort) begin
        st = 0; req_d = 1'b0; words_done = 1'b0;
      end
      case (st)
        0: begin
          tx_data_req = spam_req;
          if (tx_start && !abort) begin
            check_eq("sb_has_pkt", 32'(exp_len.size() > 0), 32'd1);
            cur_len  = (exp_len.size() > 0)  ? exp_len.pop_front()  : 16'hxxxx;
            cur_seq  = (exp_seq.size() > 0)  ? exp_seq.pop_front()  : 16'hxxxx;
            cur_cnt  = (exp_cnt.size() > 0)  ? exp_cnt.pop_front()  : 16'hxxxx;
            cur_rden = (exp_rden.size() > 0) ? exp_rden.pop_front() : -1;
            check_eq("tx_len", 32'(tx_len), 32'(cur_len));
            nwords = int'(cur_len) / 2;
            w = 0; got = 0; gap_left = 0; rden_base = rden_total; first = 1'b1;
            st = 1;
          end
        end
        1: begin
          if (first) check_eq("start_one_cycle", 32'(tx_start), 32'd0);
          first = 1'b0;
          if (req_d) begin
            if (got == 0)      e = 16'hA55A;
            else if (got == 1) e = cur_seq;
            else if (exp_pay.size() > 0) e = exp_pay.pop_front();
            else               e = 16'hxxxx;
            check_eq(got == 0 ? "hdr_magic" : (got == 1 ? "hdr_seq" : "payload"), 32'(tx_data), 32'(e));
            last_exp = e;
            got++;
          end else if (got > 0) begin
            check_eq("data_hold", 32'(tx_data), 32'(last_exp));
          end
          if (got >= nwords) begin
            tx_data_req = 1'b0; req_d = 1'b0; words_done = 1'b1; dly = 0; st = 2;
          end else begin
            req = 1'b0;
            if (gap_left > 0) gap_left--;
            else if (w < nwords && (w < 2 || (w - 2) < req_limit)) begin
              req = 1'b1; w++;
              if (gap_mode && $urandom_range(0, 3) == 0) gap_left = $urandom_range(1, 5);
            end
            tx_data_req = req; req_d = req;
          end
        end
        2: begin
          dly++;
          if (dly == 6) begin
            check_eq("tx_len_stable", 32'(tx_len), 32'(cur_len));
            tx_done = 1'b1;
            st = 3;
          end
        end
        default: begin
          check_eq("pkt_cnt", 32'(pkt_cnt), 32'(cur_cnt));
          check_eq("rden_count", 32'(rden_total - rden_base), 32'(cur_rden));
          pkts_done++;
          words_done = 1'b0;
          st = 0;
        end
      endcase
    end
  end

  // Stimulus helpers
  task automatic drive_words(input int n, input logic [15:0] base, input bit push_exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en  = 1'b1;
      wr_dat = base + 16'(i);
      if (push_exp) exp_pay.push_back(wr_dat);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic expect_pkt(input int words, input int seq, input int cnt, input int rdens);
    exp_len.push_back(16'((words + 2) * 2));
    exp_seq.push_back(16'(seq));
    exp_cnt.push_back(16'(cnt));
    exp_rden.push_back(rdens);
  endtask

  task automatic pulse_done();
    @(negedge clk) eth_done_pulse = 1'b1;
    @(negedge clk) eth_done_pulse = 1'b0;
  endtask

  task automatic wait_pkts(input int target);
    int k = 0;
    while (pkts_done < target && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check_eq("pkts_done", 32'(pkts_done), 32'(target));
  endtask

  task automatic wait_got(input int target);
    int k = 0;
    while (got < target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_eq("words_seen", 32'(got >= target), 32'd1);
  endtask

  int base_rden;

  initial begin
    reset_n = 1'b0; eth_busy = 1'b0; eth_done_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_len", 32'(tx_len), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_fifo_rden", 32'(fifo_rden), 32'd0);
    reset_n = 1'b1;
    @(negedge clk) eth_busy = 1'b1;

    // One full packet from a 0..511 ramp
    expect_pkt(512, 0, 1, 512);
    drive_words(512, 16'h0000, 1'b1);
    wait_pkts(1);
    check_eq("t1_underflow", 32'(underflow), 32'd0);

    // New job, 1100 words plus flush, stalled requests
    @(negedge clk) eth_busy = 1'b0;
    @(negedge clk) eth_busy = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("job_clr_cnt", 32'(pkt_cnt), 32'd0);
    gap_mode = 1'b1;
    expect_pkt(512, 0, 1, 512);
    expect_pkt(512, 1, 2, 512);
    expect_pkt(76, 2, 3, 76);
    drive_words(1100, 16'h1000, 1'b1);
    pulse_done();
    wait_pkts(4);
    repeat (3) @(negedge clk);
    check_eq("flush_cleared", 32'(dut.r_flush_pending), 32'd0);
    gap_mode = 1'b0;

    // FIFO drained after 300 payload words
    expect_pkt(512, 3, 4, 300);
    for (int i = 0; i < 300; i++) exp_pay.push_back(16'h2000 + 16'(i));
    for (int i = 0; i < 212; i++) exp_pay.push_back(16'h0000);
    req_limit = 300;
    drive_words(512, 16'h2000, 1'b0);
    wait_got(302);
    check_eq("uf_before", 32'(underflow), 32'd0);
    @(negedge clk) clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
    req_limit = 4096;
    wait_pkts(5);
    check_eq("uf_after", 32'(underflow), 32'd1);

    // Job restart raised while waiting for tx_done of the seq=5 packet
    expect_pkt(10, 4, 5, 10);
    drive_words(10, 16'h4000, 1'b1);
    pulse_done();
    wait_pkts(6);
    @(negedge clk) eth_busy = 1'b0;
    expect_pkt(8, 5, 6, 8);
    drive_words(8, 16'h5000, 1'b1);
    pulse_done();
    begin
      int k = 0;
      while (!words_done && k < 2000) begin
        @(negedge clk);
        k++;
      end
    end
    check_eq("seq_in_wait", 32'(dut.r_seq), 32'd5);
    eth_busy = 1'b1;
    wait_pkts(7);
    repeat (2) @(negedge clk);
    check_eq("pend_clr_cnt", 32'(pkt_cnt), 32'd0);
    check_eq("pend_clr_seq", 32'(dut.r_seq), 32'd0);
    check_eq("pend_clr_uf", 32'(underflow), 32'd0);
    expect_pkt(4, 0, 1, 4);
    drive_words(4, 16'h6000, 1'b1);
    pulse_done();
    wait_pkts(8);

    // Reset in the middle of a payload
    expect_pkt(512, 1, 2, 512);
    drive_words(512, 16'h7000, 1'b1);
    wait_got(100);
    @(negedge clk);
    reset_n = 1'b0;
    abort   = 1'b1;
    #1;
    check_eq("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("mid_rst_tx_len", 32'(tx_len), 32'd0);
    check_eq("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check_eq("mid_rst_rden", 32'(fifo_rden), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    spam_req  = 1'b1;
    base_rden = rden_total;
    repeat (50) @(negedge clk);
    check_eq("no_rden_after_rst", 32'(rden_total - base_rden), 32'd0);
    check_eq("no_start_after_rst", 32'(dut.r_state == 3'd0), 32'd1);
    spam_req = 1'b0;
    exp_pay.delete();
    @(negedge clk) clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
